// File: rtl/sram_page_manager_if.sv
// Handshake bundle for sram_page_manager: packet write port, completion report,
// chain read port and free-page count.
interface sram_page_manager_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PAGE_WORDS = 8,
  parameter int NUM_PAGES  = 2048,
  parameter int PAGE_AW    = $clog2(NUM_PAGES)
);
  logic                  wr_vld;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_eop;
  logic                  wr_ready;
  logic                  pkt_done;
  logic [PAGE_AW-1:0]    pkt_head;
  logic [PAGE_AW-1:0]    pkt_tail;
  logic [PAGE_AW:0]      pkt_pages;
  logic                  rd_start;
  logic [PAGE_AW-1:0]    rd_head;
  logic [PAGE_AW:0]      rd_pages;
  logic                  rd_busy;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic [PAGE_AW:0]      free_count;

  modport master (
    output wr_vld, wr_data, wr_eop, rd_start, rd_head, rd_pages,
    input  wr_ready, pkt_done, pkt_head, pkt_tail, pkt_pages,
           rd_busy, rd_vld, rd_data, rd_last, free_count
  );

  modport slave (
    input  wr_vld, wr_data, wr_eop, rd_start, rd_head, rd_pages,
    output wr_ready, pkt_done, pkt_head, pkt_tail, pkt_pages,
           rd_busy, rd_vld, rd_data, rd_last, free_count
  );
endinterface

// File: rtl/sram_page_manager.sv
// Paged packet buffer for one SRAM bank: free-page list, jump-table chaining on
// write, chain walk with page release on read.
module sram_page_manager #(
  parameter int DATA_WIDTH = 16,
  parameter int PAGE_WORDS = 8,
  parameter int NUM_PAGES  = 2048,
  parameter int PAGE_AW    = $clog2(NUM_PAGES)
) (
  input logic                clk,
  input logic                rst,
  sram_page_manager_if.slave bus
);
  localparam int WORD_AW = $clog2(PAGE_WORDS);
  localparam int ADDR_W  = PAGE_AW + WORD_AW;

  typedef enum logic {W_IDLE, W_WRITE} wstate_t;
  typedef enum logic {R_IDLE, R_READ}  rstate_t;

  logic [DATA_WIDTH-1:0] mem        [NUM_PAGES*PAGE_WORDS];
  logic [PAGE_AW-1:0]    jump_table [NUM_PAGES];
  logic [PAGE_AW-1:0]    fifo       [NUM_PAGES];

  // free list
  logic [PAGE_AW:0]   init_cnt;
  logic [PAGE_AW-1:0] fifo_rd, fifo_wr;
  logic [PAGE_AW:0]   free_cnt;
  logic               init_done;
  logic [PAGE_AW-1:0] alloc_page;
  logic               alloc, free_push;

  // write side
  wstate_t            wstate;
  logic [WORD_AW-1:0] word_idx;
  logic [PAGE_AW-1:0] cur_wpage, head_page;
  logic [PAGE_AW:0]   wpages, pages_nxt;
  logic [PAGE_AW-1:0] wr_page;
  logic [ADDR_W-1:0]  wr_addr;
  logic               wr_accept;
  logic               pkt_done_q;
  logic [PAGE_AW-1:0] pkt_head_q, pkt_tail_q;
  logic [PAGE_AW:0]   pkt_pages_q;

  // read side
  rstate_t               rstate;
  logic [WORD_AW-1:0]    rword;
  logic [PAGE_AW-1:0]    cur_rpage;
  logic [PAGE_AW:0]      rpages_left;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_go, rd_page_end;
  logic                  rd_busy_q, rd_vld_q, rd_last_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // init counter reaches NUM_PAGES (a power of two) exactly when its MSB sets
  assign init_done  = init_cnt[PAGE_AW];
  assign alloc_page = init_done ? fifo[fifo_rd] : init_cnt[PAGE_AW-1:0];

  assign bus.wr_ready = !rst && (word_idx != '0 || free_cnt != '0);
  assign wr_accept    = bus.wr_vld && bus.wr_ready;
  assign alloc        = wr_accept && word_idx == '0;
  assign wr_page      = (word_idx == '0) ? alloc_page : cur_wpage;
  assign wr_addr      = {wr_page, word_idx};
  assign pages_nxt    = (wstate == W_IDLE) ? (PAGE_AW+1)'(1)
                                           : wpages + (PAGE_AW+1)'(word_idx == '0);

  assign rd_page_end = rstate == R_READ && rword == WORD_AW'(PAGE_WORDS-1);
  assign free_push   = rd_page_end;
  assign rd_addr     = {cur_rpage, rword};
  assign rd_go       = bus.rd_start && rstate == R_IDLE && !rd_busy_q && bus.rd_pages != '0;

  assign bus.free_count = free_cnt;
  assign bus.pkt_done   = pkt_done_q;
  assign bus.pkt_head   = pkt_head_q;
  assign bus.pkt_tail   = pkt_tail_q;
  assign bus.pkt_pages  = pkt_pages_q;
  assign bus.rd_busy    = rd_busy_q;
  assign bus.rd_vld     = rd_vld_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_last    = rd_last_q;

  // storage arrays are never reset
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_addr] <= bus.wr_data;
    if (alloc && wstate == W_WRITE) jump_table[cur_wpage] <= alloc_page;
    if (free_push) fifo[fifo_wr] <= cur_rpage;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt <= '0;
      fifo_rd  <= '0;
      fifo_wr  <= '0;
      free_cnt <= (PAGE_AW+1)'(NUM_PAGES);
    end else begin
      if (alloc) begin
        if (init_done) fifo_rd  <= fifo_rd + 1'b1;
        else           init_cnt <= init_cnt + 1'b1;
      end
      if (free_push) fifo_wr <= fifo_wr + 1'b1;
      free_cnt <= free_cnt + (PAGE_AW+1)'(free_push) - (PAGE_AW+1)'(alloc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate      <= W_IDLE;
      word_idx    <= '0;
      cur_wpage   <= '0;
      head_page   <= '0;
      wpages      <= '0;
      pkt_done_q  <= 1'b0;
      pkt_head_q  <= '0;
      pkt_tail_q  <= '0;
      pkt_pages_q <= '0;
    end else begin
      pkt_done_q <= 1'b0;
      if (wr_accept) begin
        if (word_idx == '0) cur_wpage <= alloc_page;
        if (wstate == W_IDLE) head_page <= alloc_page;
        wpages   <= pages_nxt;
        word_idx <= bus.wr_eop ? '0 : word_idx + 1'b1;
        wstate   <= bus.wr_eop ? W_IDLE : W_WRITE;
        if (bus.wr_eop) begin
          pkt_done_q  <= 1'b1;
          pkt_head_q  <= (wstate == W_IDLE) ? alloc_page : head_page;
          pkt_tail_q  <= wr_page;
          pkt_pages_q <= pages_nxt;
        end
      end
    end
  end

  // rd_busy stays up through the rd_last cycle, so a new start lands one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      rstate      <= R_IDLE;
      rword       <= '0;
      cur_rpage   <= '0;
      rpages_left <= '0;
      rd_busy_q   <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      rd_busy_q <= rstate == R_READ || rd_go;
      rd_vld_q  <= rstate == R_READ;
      rd_last_q <= 1'b0;
      if (rstate == R_READ) begin
        rd_data_q <= mem[rd_addr];
        rword     <= rword + 1'b1;
        if (rd_page_end) begin
          cur_rpage   <= jump_table[cur_rpage];
          rpages_left <= rpages_left - 1'b1;
          if (rpages_left == (PAGE_AW+1)'(1)) begin
            rd_last_q <= 1'b1;
            rstate    <= R_IDLE;
          end
        end
      end else if (rd_go) begin
        cur_rpage   <= bus.rd_head;
        rpages_left <= bus.rd_pages;
        rword       <= '0;
        rstate      <= R_READ;
      end
    end
  end
endmodule
